alu_exec: RTL and testbench

Execute-stage ALU that consumes the 4-bit `ALU_Control` code produced by `ALU_Control` and performs the selected operation on two operands. Add, logic, compare and branch-compare operations complete in one cycle. Shifts run iteratively, one bit per cycle. A valid/ready handshake sits on both sides, so the block can stall the pipeline during multi-cycle shifts and hold a result under downstream backpressure.

---
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec.sv | 148 ++++++++++++++
 tb/tb_alu_exec.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec request/result handshake bundle.
// master drives requests and accepts results; slave is the ALU.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             branch_taken;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/logic/compare/branch,
// iterative one-bit-per-cycle shifts, valid/ready on both sides.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b;
  logic [3:0]       ctrl;
  logic [SHW-1:0]   shamt;
  logic [SHW-1:0]   cnt;
  logic [1:0]       sh_op;
  logic [1:0]       sh_op_nx;
  logic             is_shift;
  logic             lt_s, lt_u, eq;
  logic [WIDTH-1:0] res;
  logic             tk;
  logic [WIDTH-1:0] step;

  assign a     = bus.op_a;
  assign b     = bus.op_b;
  assign ctrl  = bus.alu_ctrl;
  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  assign is_shift = (ctrl == 4'b0001)
                 || (ctrl == 4'b0101)
                 || (ctrl == 4'b1011);

  // 1: SLL, 2: SRL, 3: SRA
  assign sh_op_nx = ctrl[3] ? 2'd3
                  : (ctrl[2] ? 2'd2 : 2'd1);

  always_comb begin
    tk  = 1'b0;
    res = '0;
    unique case (ctrl)
      4'b0000: res = a + b;
      4'b1010: res = a - b;
      4'b0001,
      4'b0101,
      4'b1011: res = a;
      4'b0010: res = {{(WIDTH-1){1'b0}}, lt_s};
      4'b0011: res = {{(WIDTH-1){1'b0}}, lt_u};
      4'b0100: res = a ^ b;
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      4'b1000: tk  = eq;
      4'b1001: tk  = !eq;
      4'b1100: tk  = lt_s;
      4'b1101: tk  = !lt_s;
      4'b1110: tk  = lt_u;
      4'b1111: tk  = !lt_u;
      default: res = '0;
    endcase
    if (ctrl[3] && !(ctrl[3:1] == 3'b101))
      res = {{(WIDTH-1){1'b0}}, tk};
  end

  // result doubles as the shift working register
  always_comb begin
    step = bus.result;
    unique case (sh_op)
      2'd1:    step = {bus.result[WIDTH-2:0], 1'b0};
      2'd2:    step = {1'b0, bus.result[WIDTH-1:1]};
      2'd3:    step = {bus.result[WIDTH-1],
                       bus.result[WIDTH-1:1]};
      default: step = bus.result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_shift && shamt != '0)
            state_nx = SHIFT;
          else
            state_nx = DONE;
        end
      end
      SHIFT: begin
        if (cnt == SHW'(1))
          state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result       <= '0;
      bus.branch_taken <= 1'b0;
      cnt              <= '0;
      sh_op            <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_op <= sh_op_nx;
            if (is_shift && shamt != '0) begin
              bus.result       <= a;
              bus.branch_taken <= 1'b0;
              cnt              <= shamt;
            end else begin
              bus.result       <= res;
              bus.branch_taken <= tk;
            end
          end
        end
        SHIFT: begin
          bus.result <= step;
          cnt        <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed cases,
// backpressure, async reset and a random sweep.
module tb_alu_exec;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    logic [31:0] r;
    logic        t;
  } exp_t;

  exp_t sbq[$];

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int   sh;
    sh  = int'(b[4:0]);
    e.r = 32'h0;
    e.t = 1'b0;
    case (c)
      4'h0: e.r = a + b;
      4'h1: e.r = a << sh;
      4'h2: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: e.r = (a < b) ? 32'd1 : 32'd0;
      4'h4: e.r = a ^ b;
      4'h5: e.r = a >> sh;
      4'h6: e.r = a | b;
      4'h7: e.r = a & b;
      4'hA: e.r = a - b;
      4'hB: e.r = $signed(a) >>> sh;
      4'h8: e.t = (a == b);
      4'h9: e.t = (a != b);
      4'hC: e.t = ($signed(a) < $signed(b));
      4'hD: e.t = ($signed(a) >= $signed(b));
      4'hE: e.t = (a < b);
      4'hF: e.t = (a >= b);
      default: e.r = 32'h0;
    endcase
    if (c[3] && c[3:1] != 3'b101)
      e.r = {31'b0, e.t};
    return e;
  endfunction

  function automatic int lat_of(input logic [3:0] c,
                                input logic [31:0] b);
    if ((c == 4'h1 || c == 4'h5 || c == 4'hB)
        && b[4:0] != 5'd0)
      return int'(b[4:0]);
    return 0;
  endfunction

  // lat: edges after the accept edge until out_valid shows
  task automatic run_op(input logic [3:0]  c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input exp_t        e,
                        input int          lat,
                        input bit          consume);
    int   n;
    bit   busy_ok;
    exp_t got;
    sbq.push_back(e);
    @(negedge clk);
    chk("rdy_pre", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.alu_ctrl = 4'($urandom);
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("timeout", 64'(n), 64'(lat));
    chk("lat", 64'(n), 64'(lat));
    chk("busy", 64'(busy_ok), 64'd1);
    chk("rdy_done", 64'(bus.in_ready), 64'd0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sbq.pop_front();
      chk("result", 64'(bus.result), 64'(got.r));
      chk("taken", 64'(bus.branch_taken), 64'(got.t));
    end
    if (consume) begin
      @(posedge clk);
      #1;
      chk("consumed", 64'(bus.out_valid), 64'd0);
    end
  endtask

  task automatic dir_op(input logic [3:0]  c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic        et,
                        input int          lat);
    exp_t e;
    e.r = er;
    e.t = et;
    run_op(c, a, b, e, lat, 1'b1);
  endtask

  initial begin
    logic [31:0] hr;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    int          seen;
    exp_t        e;

    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'h0;
    bus.op_a      = 32'h0;
    bus.op_b      = 32'h0;
    bus.out_ready = 1'b1;

    #3 rst = 1'b1;
    #1;
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_res", 64'(bus.result), 64'd0);
    chk("rst_tk", 64'(bus.branch_taken), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    dir_op(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
    dir_op(4'hA, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 0);
    dir_op(4'hB, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 4);
    dir_op(4'h5, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 4);
    dir_op(4'h1, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 31);
    dir_op(4'h1, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 0);
    dir_op(4'hC, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 0);
    dir_op(4'hE, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
    dir_op(4'hD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
    dir_op(4'hF, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 0);
    dir_op(4'h8, 32'h55, 32'h55, 32'h1, 1'b1, 0);
    dir_op(4'h9, 32'h55, 32'h55, 32'h0, 1'b0, 0);
    dir_op(4'h2, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 0);
    dir_op(4'h3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);

    // backpressure: hold result for 5 cycles
    bus.out_ready = 1'b0;
    e.r = 32'h0F00_F000;
    e.t = 1'b0;
    run_op(4'h7, 32'hFF0F_F0F0, 32'h0FF0_F00F,
           e, 0, 1'b0);
    hr = bus.result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ov", 64'(bus.out_valid), 64'd1);
      chk("bp_rdy", 64'(bus.in_ready), 64'd0);
      chk("bp_res", 64'(bus.result), 64'(32'h0F00_F000));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", 64'(bus.in_ready), 64'd1);
    chk("bp_ovlo", 64'(bus.out_valid), 64'd0);
    dir_op(4'h6, 32'hF000_000F, 32'h0F00_00F0,
           32'hFF00_00FF, 1'b0, 0);

    // async reset while holding a taken branch in DONE
    bus.out_ready = 1'b0;
    e.r = 32'h1;
    e.t = 1'b1;
    run_op(4'h8, 32'h7, 32'h7, e, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rd_ov", 64'(bus.out_valid), 64'd0);
    chk("rd_rdy", 64'(bus.in_ready), 64'd1);
    chk("rd_res", 64'(bus.result), 64'd0);
    chk("rd_tk", 64'(bus.branch_taken), 64'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    // async reset mid-shift discards the op
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'h1;
    bus.op_a     = 32'h1;
    bus.op_b     = 32'd10;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rs_busy", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rs_rdy", 64'(bus.in_ready), 64'd1);
    chk("rs_ov", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("rs_noov", 64'(seen), 64'd0);

    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ra;
      run_op(rc, ra, rb, model(rc, ra, rb),
             lat_of(rc, rb), 1'b1);
    end

    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
